// File: rtl/frame_streamer_if.sv
// dstream: valid/ready pixel stream carrying a W-bit payload.
// The producer drives data/valid through modport out, the consumer drives ready.
interface dstream #(
    parameter int W = 30
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport out (output data, output valid, input ready);
    modport in  (input data, input valid, output ready);
endinterface

// File: rtl/frame_streamer.sv
// frame_streamer: reads a WIDTH x HEIGHT frame from a frame buffer in raster order
// and streams it out over a dstream, tagging start-of-frame and end-of-line.
// Reads are throttled so the 2-entry output FIFO can never overflow.
// Optional macro FRAME_STREAMER_LOOP_EN: stream frames back to back forever
// after a single start (DRAIN is then never entered).
module frame_streamer #(
    parameter int W      = 30,
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          rd_en,
    output logic [16:0]   rd_addr,
    input  logic [W-1:0]  rd_data,
    dstream.out           y,
    output logic          sof,
    output logic          eol,
    output logic          busy,
    output logic          frame_done
);
    localparam int          CW        = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int          LW        = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [16:0] LAST_ADDR = 17'(WIDTH * HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

    // FIFO entry: pixel plus the raster tags that travel with it
    typedef struct packed {
        logic [W-1:0] data;
        logic         sof;
        logic         eol;
        logic         eof;
    } pix_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   col;
    logic [LW-1:0]   line;
    logic            rd_vld_q;
    logic [2:0]      rd_tag_q;
    pix_t            fifo_mem [2];
    logic            wr_ptr, rd_ptr;
    logic [1:0]      count;
    logic            fifo_nempty;
    logic            push, pop;
    logic [2:0]      level;
    logic            tag_sof, tag_eol, tag_eof;
    pix_t            head;

    assign fifo_nempty = (count != 2'd0);
    assign head        = fifo_mem[rd_ptr];
    assign push        = rd_vld_q;
    assign pop         = fifo_nempty & y.ready;
    // Slots already committed once this cycle's transfer (if any) is accounted for
    assign level       = {1'b0, count} + {2'b0, rd_vld_q} - {2'b0, pop};

    assign tag_sof = (rd_addr == 17'd0);
    assign tag_eol = (col == CW'(WIDTH - 1));
    assign tag_eof = (rd_addr == LAST_ADDR);

    // Gate the head with valid so an empty FIFO presents an all-zero stream
    assign y.valid = fifo_nempty;
    assign y.data  = fifo_nempty ? head.data : '0;
    assign sof     = fifo_nempty & head.sof;
    assign eol     = fifo_nempty & head.eol;
    assign busy    = (state != IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and read-strobe decode
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = STREAM;
            end
            STREAM: begin
                rd_en = (level < 3'd2);
                if (rd_en && tag_eof) begin
`ifdef FRAME_STREAMER_LOOP_EN
                    state_nxt = STREAM;
`else
                    state_nxt = DRAIN;
`endif
                end
            end
            DRAIN: begin
                if (pop && head.eof) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Raster address and column/line counters; the last read wraps everything to 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr <= '0;
            col     <= '0;
            line    <= '0;
        end else if (rd_en) begin
            if (tag_eof) begin
                rd_addr <= '0;
                col     <= '0;
                line    <= '0;
            end else begin
                rd_addr <= rd_addr + 17'd1;
                if (tag_eol) begin
                    col  <= '0;
                    line <= (line == LW'(HEIGHT - 1)) ? '0 : line + LW'(1);
                end else begin
                    col  <= col + CW'(1);
                end
            end
        end
    end

    // One-deep read pipeline: marks the cycle rd_data is valid and carries its tags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_q <= 1'b0;
            rd_tag_q <= '0;
        end else begin
            rd_vld_q <= rd_en;
            if (rd_en) rd_tag_q <= {tag_sof, tag_eol, tag_eof};
        end
    end

    // 2-entry output FIFO; push and pop in the same cycle keep occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= '{data: rd_data, sof: rd_tag_q[2],
                                      eol: rd_tag_q[1], eof: rd_tag_q[0]};
                wr_ptr <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Frame-complete pulse, one cycle after the last pixel transfers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_done <= 1'b0;
        else        frame_done <= pop & head.eof;
    end
endmodule

// File: tb/tb_frame_streamer.sv
// tb_frame_streamer: directed bench on a small 8x4 frame; memory returns data = address.
module tb_frame_streamer;
    localparam int W      = 30;
    localparam int WIDTH  = 8;
    localparam int HEIGHT = 4;
    localparam int NPIX   = WIDTH * HEIGHT;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          rd_en;
    logic [16:0]   rd_addr;
    logic [W-1:0]  rd_data = '0;
    logic          sof, eol, busy, frame_done;
    logic          y_ready = 1'b1;

    dstream #(.W(W)) y_if ();
    assign y_if.ready = y_ready;

    frame_streamer #(.W(W), .WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .y(y_if), .sof(sof), .eol(eol), .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Frame-buffer model: one-cycle read latency, data equals address
    always @(posedge clk) rd_data <= W'(rd_addr);

    int checks = 0;
    int failures = 0;
    logic [31:0] xfer_q [$];   // {sof, eol, data}
    int          fd_q [$];     // transfer count seen at each frame_done
    int          rd_cnt;
    logic        stall_q;
    logic [W-1:0] held;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        xfer_q.delete();
        fd_q.delete();
        rd_cnt  = 0;
        stall_q = 1'b0;
    endtask

    // One cycle: set ready for the coming edge, then record what that edge will do.
    // mode 0: ready=1, 1: toggle, 2: ready=0
    task automatic tick(input int mode);
        @(negedge clk);
        case (mode)
            0:       y_ready = 1'b1;
            1:       y_ready = ~y_ready;
            default: y_ready = 1'b0;
        endcase
        #1;
        if (stall_q) begin
            chk("hold_valid", 32'(y_if.valid), 32'd1);
            chk("hold_data", 32'(y_if.data), 32'(held));
        end
        if (y_if.valid && y_ready) xfer_q.push_back({sof, eol, y_if.data});
        stall_q = y_if.valid && !y_ready;
        held    = y_if.data;
        if (frame_done) fd_q.push_back(xfer_q.size());
        if (rd_en) rd_cnt++;
    endtask

    task automatic chk_frame(input string tag, input int base);
        for (int k = 0; k < NPIX; k++) begin
            chk(tag, xfer_q[base + k],
                {(k == 0), (k % WIDTH == WIDTH - 1), W'(k)});
        end
    endtask

    task automatic run_to_done(input string tag, input int mode, input int nfd, input int budget);
        int n;
        n = 0;
        while (fd_q.size() < nfd && n < budget) begin
            tick(mode);
            n++;
        end
        chk(tag, 32'(fd_q.size()), 32'(nfd));
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_rd_en"}, 32'(rd_en), 32'd0);
        chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
        chk({tag, "_valid"}, 32'(y_if.valid), 32'd0);
        chk({tag, "_data"}, 32'(y_if.data), 32'd0);
        chk({tag, "_sof_eol"}, {30'd0, sof, eol}, 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_fdone"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        #1;
        chk_reset_outs("rst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef FRAME_STREAMER_LOOP_EN
        // Back-to-back frames from a single start
        clr();
        start = 1'b1;
        tick(0);
        start = 1'b0;
        run_to_done("loop_done", 0, 3, 4 * NPIX);
        if (xfer_q.size() >= 2 * NPIX) begin
            chk_frame("loop_f0", 0);
            chk_frame("loop_f1", NPIX);
        end else chk("loop_count", 32'(xfer_q.size()), 32'(2 * NPIX));
        chk("loop_fd0", 32'(fd_q[0]), 32'(NPIX));
        chk("loop_fd1", 32'(fd_q[1]), 32'(2 * NPIX));
        chk("loop_busy", 32'(busy), 32'd1);
`else
        // A: latency, raster tags and frame_done timing with ready held high
        y_ready = 1'b1;
        start = 1'b1;                       // cycle 0
        @(negedge clk);                     // cycle 1
        start = 1'b0;
        chk("A_rd_en1", 32'(rd_en), 32'd1);
        chk("A_addr1", 32'(rd_addr), 32'd0);
        chk("A_busy", 32'(busy), 32'd1);
        @(negedge clk);                     // cycle 2
        chk("A_valid2", 32'(y_if.valid), 32'd0);
        chk("A_addr2", 32'(rd_addr), 32'd1);
        @(negedge clk);                     // cycle 3
        for (int k = 0; k < NPIX; k++) begin
            chk("A_valid", 32'(y_if.valid), 32'd1);
            chk("A_pix", {sof, eol, y_if.data}, {(k == 0), (k % WIDTH == WIDTH - 1), W'(k)});
            @(negedge clk);
        end                                 // cycle 3 + NPIX
        chk("A_fdone", 32'(frame_done), 32'd1);
        chk("A_idle", 32'(busy), 32'd0);
        chk("A_valid_end", 32'(y_if.valid), 32'd0);
        @(negedge clk);
        chk("A_fdone_pulse", 32'(frame_done), 32'd0);

        // B: ready toggling every cycle
        clr();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        run_to_done("B_done", 1, 1, 6 * NPIX);
        repeat (4) tick(1);
        chk("B_count", 32'(xfer_q.size()), 32'(NPIX));
        if (xfer_q.size() == NPIX) chk_frame("B_pix", 0);
        chk("B_fd", 32'(fd_q.size()), 32'd1);

        // C: consumer stalled for 50 cycles after start
        clr();
        start = 1'b1;
        tick(2);
        start = 1'b0;
        repeat (49) tick(2);
        chk("C_reads", 32'(rd_cnt), 32'd2);
        chk("C_valid", 32'(y_if.valid), 32'd1);
        chk("C_data", 32'(y_if.data), 32'd0);
        run_to_done("C_done", 0, 1, 4 * NPIX);
        chk("C_count", 32'(xfer_q.size()), 32'(NPIX));
        if (xfer_q.size() == NPIX) chk_frame("C_pix", 0);

        // D: reset mid-frame, then a fresh frame from address 0
        clr();
        start = 1'b1;
        tick(0);
        start = 1'b0;
        for (int n = 0; n < 4 * NPIX && xfer_q.size() < 10; n++) tick(0);
        chk("D_reached", 32'(xfer_q.size()), 32'd10);
        rst_n = 1'b0;
        #1;
        chk_reset_outs("D_rst");
        @(negedge clk);
        rst_n = 1'b1;
        clr();
        repeat (5) tick(0);
        chk("D_quiet", 32'(xfer_q.size()), 32'd0);
        start = 1'b1;
        tick(0);
        start = 1'b0;
        run_to_done("D_done", 0, 1, 4 * NPIX);
        chk("D_count", 32'(xfer_q.size()), 32'(NPIX));
        if (xfer_q.size() == NPIX) chk_frame("D_pix", 0);

        // E: start pulses while busy (mid-stream and in the drain) are ignored
        clr();
        start = 1'b1;
        tick(0);
        start = 1'b0;
        for (int n = 0; n < 3 * NPIX; n++) begin
            tick(0);
            start = (n == 5) || (xfer_q.size() == NPIX - 1);
        end
        start = 1'b0;
        chk("E_count", 32'(xfer_q.size()), 32'(NPIX));
        chk("E_fd", 32'(fd_q.size()), 32'd1);
        chk("E_idle", 32'(busy), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
